// File: rtl/gf2m_digit_feeder.sv
// ---------------------------------------------------------------------------
// gf2m_digit_feeder
//   Control stage in front of a digit-serial GF(2^m) multiplier. Accepts an
//   operand triple (a, b, g), pulses the multiplier start, streams b to it one
//   DIGITAL-bit digit per iteration (most significant digit first), captures
//   the product on mul_done and offers it downstream. A watchdog raises a
//   sticky err if the multiplier never completes, or completes too early.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake; in_a, in_b, in_g operands
//   mul_start                one-cycle start pulse to the multiplier
//   mul_a, mul_g             latched operands, stable until the next accept
//   mul_b                    current b digit (zero outside START/FEED)
//   mul_t, mul_done          multiplier result and done pulse
//   out_valid/out_ready      result handshake; out_c captured product
//   err                      sticky error (timeout or premature done)
// ---------------------------------------------------------------------------
module gf2m_digit_feeder #(
   parameter int DIGITAL    = 64,
   parameter int DATA_WIDTH = 163,
   parameter int NUM_DIGITS = (DATA_WIDTH + DIGITAL - 1) / DIGITAL,
   parameter int TIMEOUT    = NUM_DIGITS + 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [DATA_WIDTH-1:0] in_g,
   output logic                  mul_start,
   output logic [DATA_WIDTH-1:0] mul_a,
   output logic [DATA_WIDTH-1:0] mul_g,
   output logic [DIGITAL-1:0]    mul_b,
   input  logic [DATA_WIDTH-1:0] mul_t,
   input  logic                  mul_done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_c,
   output logic                  err
);

   localparam int PAD_W = NUM_DIGITS * DIGITAL;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_HOLD} state_t;

   state_t                r_state, w_next;
   logic [PAD_W-1:0]      r_b;        // padded b, shifted left one digit per FEED cycle
   logic [CNT_W-1:0]      r_cnt;
   logic [WD_W-1:0]       r_wd;
   logic [DATA_WIDTH-1:0] r_a, r_g, r_c;
   logic                  r_out_valid, r_err;
   logic                  w_accept, w_capture, w_timeout, w_spurious;
   logic [DIGITAL-1:0]    w_top;

   // The current digit always sits in the top slot of the shift register.
   assign w_top     = r_b[PAD_W-1 -: DIGITAL];
   assign mul_a     = r_a;
   assign mul_g     = r_g;
   assign out_c     = r_c;
   assign out_valid = r_out_valid;
   assign err       = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      in_ready   = 1'b0;
      mul_start  = 1'b0;
      mul_b      = '0;
      w_accept   = 1'b0;
      w_capture  = 1'b0;
      w_timeout  = 1'b0;
      w_spurious = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready   = 1'b1;
            w_spurious = mul_done;
            if (in_valid) begin
               w_accept = 1'b1;
               w_next   = S_START;
            end
         end
         S_START: begin
            mul_start  = 1'b1;
            mul_b      = w_top;
            w_spurious = mul_done;
            w_next     = S_FEED;
         end
         S_FEED: begin
            mul_b      = w_top;
            w_spurious = mul_done;
            if (r_cnt == CNT_LAST) w_next = S_WAIT;
         end
         S_WAIT: begin
            // A real done wins over a watchdog expiring on the same cycle.
            if (mul_done) begin
               w_capture = 1'b1;
               w_next    = S_HOLD;
            end else if (r_wd == WD_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_HOLD: begin
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a         <= '0;
         r_g         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_cnt       <= '0;
         r_wd        <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a <= in_a;
            r_g <= in_g;
            r_b <= PAD_W'(in_b);
         end
         if (r_state == S_START) r_cnt <= '0;
         if (r_state == S_FEED) begin
            r_cnt <= r_cnt + 1'b1;
            r_b   <= r_b << DIGITAL;
            r_wd  <= '0;
         end
         if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
         if (w_capture) begin
            r_c         <= mul_t;
            r_out_valid <= 1'b1;
         end
         if (r_state == S_HOLD && out_ready) r_out_valid <= 1'b0;
         if (w_timeout || w_spurious) r_err <= 1'b1;
      end
   end

endmodule
